// File: rtl/inv_shift_rows_unit.sv
// inv_shift_rows_unit: byte-serial AES InvShiftRows stage.
// Collects 16 state bytes, permutes the rows and hands the block on as one word.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_data/in_valid      byte stream in; in_ready = assembly buffer not full
//   stateOut/out_valid    permuted 128-bit block out ([0:127], byte i = bits 8i..8i+7)
//   out_ready             downstream accepts stateOut
//   dir                   only with INV_SR_DIR_SEL_EN: 1 = forward ShiftRows, 0 = inverse
//
// Build option: define INV_SR_DIR_SEL_EN to add the dir port and a per-block
// direction flop; without it the inverse map is hard-wired.
module inv_shift_rows_unit #(
    parameter int BLOCK_BYTES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] stateOut,
    output logic         out_valid,
    input  logic         out_ready
`ifdef INV_SR_DIR_SEL_EN
    ,
    input  logic         dir
`endif
);

    if (BLOCK_BYTES != 16) begin : g_bad_block_bytes
        $error("inv_shift_rows_unit: BLOCK_BYTES must be 16");
    end

    // Byte (r, c) sits at index r + 4c, so the source index is {col, row}.
    function automatic logic [0:127] shift_map(
        input logic [15:0][7:0] a,
        input logic             fwd
    );
        logic [0:127] res;
        logic [1:0]   col;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                col = fwd ? 2'(c + r) : 2'(c - r);
                res[8*(r+4*c) +: 8] = a[{col, 2'(r)}];
            end
        end
        return res;
    endfunction

    logic [15:0][7:0] asm_q, asm_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             asm_full_q, asm_full_d;
    logic             out_valid_q, out_valid_d;
    logic [0:127]     state_q, state_d;
    logic             accept;
    logic             xfer;
    logic             fwd_sel;

`ifdef INV_SR_DIR_SEL_EN
    logic dir_q, dir_d;
    assign fwd_sel = dir_q;
`else
    assign fwd_sel = 1'b0;
`endif

    assign in_ready  = !asm_full_q;
    assign out_valid = out_valid_q;
    assign stateOut  = state_q;

    assign accept = in_valid && !asm_full_q;
    assign xfer   = asm_full_q && (!out_valid_q || out_ready);

    always_comb begin
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        asm_full_d  = asm_full_q;
        out_valid_d = out_valid_q;
        state_d     = state_q;
`ifdef INV_SR_DIR_SEL_EN
        dir_d       = dir_q;
        // Direction is latched with byte 0 and ignored for the rest of the block.
        if (accept && cnt_q == 4'd0) begin
            dir_d = dir;
        end
`endif
        if (accept) begin
            asm_d[cnt_q] = in_data;
            cnt_d        = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                asm_full_d = 1'b1;
            end
        end
        // accept and xfer are mutually exclusive: accept needs !asm_full.
        if (xfer) begin
            state_d     = shift_map(asm_q, fwd_sel);
            out_valid_d = 1'b1;
            asm_full_d  = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        asm_q <= asm_d;
        if (rst) begin
            cnt_q       <= 4'd0;
            asm_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            asm_full_q  <= asm_full_d;
            out_valid_q <= out_valid_d;
            state_q     <= state_d;
        end
    end

`ifdef INV_SR_DIR_SEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

endmodule

// File: tb/tb_inv_shift_rows_unit.sv
// tb_inv_shift_rows_unit: directed checks of inv_shift_rows_unit.
// Expected blocks are hand-derived constants.
module tb_inv_shift_rows_unit;

    logic         clk;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] stateOut;
    logic         out_valid;
    logic         out_ready;
`ifdef INV_SR_DIR_SEL_EN
    logic         dir;
    logic         dir_first;
`endif

    int checks;
    int failures;

    localparam logic [127:0] SEQ_00 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] INV_00 = 128'h000D0A07_04010E0B_0805020F_0C090603;
    localparam logic [127:0] FWD_00 = 128'h00050A0F_04090E03_080D0207_0C01060B;
    localparam logic [127:0] SEQ_10 = 128'h10111213_14151617_18191A1B_1C1D1E1F;
    localparam logic [127:0] INV_10 = 128'h101D1A17_14111E1B_1815121F_1C191613;
    localparam logic [127:0] SEQ_A0 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] INV_A0 = 128'hA0ADAAA7_A4A1AEAB_A8A5A2AF_ACA9A6A3;

    inv_shift_rows_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stateOut  (stateOut),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef INV_SR_DIR_SEL_EN
        ,
        .dir       (dir)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sends byte n of blk (byte 0 = most significant), starting and ending on a negedge.
    task automatic send_byte(input logic [127:0] blk, input int n);
        int waited;
        in_data  = blk[127-8*n -: 8];
        in_valid = 1'b1;
`ifdef INV_SR_DIR_SEL_EN
        dir = (n == 0) ? dir_first : !dir_first;
`endif
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 128'(in_ready), 128'd1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            send_byte(blk, i);
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap)) @(negedge clk);
            end
        end
    endtask

    task automatic expect_out(input string tag, input logic [127:0] exp);
        int waited;
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 128'(out_valid), 128'd1);
        chk(tag, stateOut, exp);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef INV_SR_DIR_SEL_EN
        dir       = 1'b0;
        dir_first = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_state", stateOut, 128'h0);

        // Back-to-back block with exact output timing.
        send_block(SEQ_00, 0);
        chk("t1_full_in_ready", 128'(in_ready), 128'd0);
        chk("t1_pre_valid", 128'(out_valid), 128'd0);
        @(negedge clk);
        chk("t1_valid", 128'(out_valid), 128'd1);
        chk("t1_state", stateOut, INV_00);
        chk("t1_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        chk("t1_drained", 128'(out_valid), 128'd0);

        // Round trip through the forward stage.
        send_block(FWD_00, 0);
        expect_out("roundtrip", SEQ_00);
        @(negedge clk);

        // Backpressure while two blocks stream in.
        out_ready = 1'b0;
        send_block(SEQ_00, 0);
        send_block(SEQ_10, 0);
        chk("bp_hold_valid", 128'(out_valid), 128'd1);
        chk("bp_hold_state", stateOut, INV_00);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        repeat (6) @(negedge clk);
        chk("bp_hold_state2", stateOut, INV_00);
        chk("bp_in_ready2", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_valid", 128'(out_valid), 128'd1);
        chk("bp_next_state", stateOut, INV_10);
        chk("bp_next_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        chk("bp_drained", 128'(out_valid), 128'd0);

        // Reset with a pending output and a partial block.
        out_ready = 1'b0;
        send_block(SEQ_00, 0);
        for (int i = 0; i < 7; i++) begin
            send_byte(SEQ_10, i);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        send_block(SEQ_A0, 0);
        chk("mid_rst_no_early", 128'(out_valid), 128'd0);
        expect_out("mid_rst_block", INV_A0);
        @(negedge clk);

        // Input gaps, then randomly toggled out_ready.
        send_block(SEQ_A0, 2);
        expect_out("gaps_block", INV_A0);
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            out_ready = 1'($urandom_range(1));
            send_block(SEQ_10, 1);
            out_ready = 1'b1;
            expect_out("rand_ready_block", INV_10);
            @(negedge clk);
        end

`ifdef INV_SR_DIR_SEL_EN
        dir_first = 1'b1;
        send_block(SEQ_00, 0);
        expect_out("dir_fwd", FWD_00);
        @(negedge clk);
        dir_first = 1'b0;
        send_block(SEQ_00, 0);
        expect_out("dir_inv", INV_00);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
